// File: rtl/mio_axis_fifo.sv
// mio_axis_fifo: AXI4-Stream synchronous FIFO, first-word-fall-through with
// a registered output stage. Null beats (tkeep==0) are dropped unless tlast.
// Optional store-and-forward packet mode: define MIO_AXIS_FIFO_PKT_MODE_EN.
// Ports:
//   clk, reset_n           clock, async active-low reset
//   s_t*                   slave (write) AXI-Stream beat + s_tready
//   m_t*                   master (read) AXI-Stream beat + m_tready
//   level                  beats held (memory + output stage), 0..DEPTH
module mio_axis_fifo #(
    parameter int TDATA_BYTES = 4,
    parameter int TID_W       = 8,
    parameter int TDEST_W     = 4,
    parameter int TUSER_W     = 1,
    parameter int DEPTH       = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic [8*TDATA_BYTES-1:0] s_tdata,
    input  logic [TDATA_BYTES-1:0]   s_tstrb,
    input  logic [TDATA_BYTES-1:0]   s_tkeep,
    input  logic                     s_tlast,
    input  logic [TID_W-1:0]         s_tid,
    input  logic [TDEST_W-1:0]       s_tdest,
    input  logic [TUSER_W-1:0]       s_tuser,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [8*TDATA_BYTES-1:0] m_tdata,
    output logic [TDATA_BYTES-1:0]   m_tstrb,
    output logic [TDATA_BYTES-1:0]   m_tkeep,
    output logic                     m_tlast,
    output logic [TID_W-1:0]         m_tid,
    output logic [TDEST_W-1:0]       m_tdest,
    output logic [TUSER_W-1:0]       m_tuser,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = 8*TDATA_BYTES + 2*TDATA_BYTES + 1
                      + TID_W + TDEST_W + TUSER_W;

    logic [PW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          s_tready_q;
    logic          m_tvalid_q;
    logic [PW-1:0] out_q;
    logic [PW-1:0] s_payload;
    logic          push, pop, load, mem_ne, elig;

    assign s_payload = {s_tdata, s_tstrb, s_tkeep, s_tlast,
                        s_tid, s_tdest, s_tuser};

    assign {m_tdata, m_tstrb, m_tkeep, m_tlast,
            m_tid, m_tdest, m_tuser} = out_q;

    assign s_tready = s_tready_q;
    assign m_tvalid = m_tvalid_q;
    assign level    = level_q;

    always_comb begin
        push    = s_tvalid && s_tready_q && ((|s_tkeep) || s_tlast);
        pop     = m_tvalid_q && m_tready;
        level_d = level_q + LW'(push) - LW'(pop);
        // level includes the beat parked in the output stage
        mem_ne  = (level_q != LW'(m_tvalid_q));
        load    = mem_ne && (!m_tvalid_q || pop) && elig;
    end

`ifdef MIO_AXIS_FIFO_PKT_MODE_EN
    logic [LW-1:0] pkt_q, pkt_d;

    always_comb begin
        pkt_d = pkt_q + LW'(push && s_tlast) - LW'(pop && m_tlast);
        // A complete packet (or a full FIFO, to avoid deadlock) must exist
        // both before and after this edge, so a pop of the last tlast beat
        // never exposes the head of an incomplete packet.
        elig  = ((pkt_q != '0) || (level_q == LW'(DEPTH)))
             && ((pkt_d != '0) || (level_d == LW'(DEPTH)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_q <= '0;
        end else begin
            pkt_q <= pkt_d;
        end
    end
`else
    assign elig = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            s_tready_q <= 1'b0;
            m_tvalid_q <= 1'b0;
            out_q      <= '0;
        end else begin
            level_q    <= level_d;
            s_tready_q <= (level_d < LW'(DEPTH));
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (load) begin
                out_q      <= mem_q[rptr_q];
                rptr_q     <= rptr_q + AW'(1);
                m_tvalid_q <= 1'b1;
            end else if (pop) begin
                m_tvalid_q <= 1'b0;
            end
        end
    end

    // Storage array carries no reset; validity is tracked by level/pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= s_payload;
        end
    end

endmodule

// File: tb/tb_mio_axis_fifo.sv
// tb_mio_axis_fifo: table vectors, directed corner sequences and random
// traffic checked against a queue-based model of the stream FIFO.
module tb_mio_axis_fifo;

    localparam int DEPTH = 16;
    localparam int PW    = 32 + 4 + 4 + 1 + 8 + 4 + 1;
    localparam int LASTB = 8 + 4 + 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tstrb = '0;
    logic [3:0]  s_tkeep = '0;
    logic        s_tlast = 1'b0;
    logic [7:0]  s_tid = '0;
    logic [3:0]  s_tdest = '0;
    logic [0:0]  s_tuser = '0;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic [7:0]  m_tid;
    logic [3:0]  m_tdest;
    logic [0:0]  m_tuser;
    logic [4:0]  level;

    always #5 clk = ~clk;

    mio_axis_fifo dut (
        .clk(clk), .reset_n(reset_n),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tkeep(s_tkeep),
        .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest),
        .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tkeep(m_tkeep),
        .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest),
        .m_tuser(m_tuser), .level(level)
    );

    typedef struct {
        logic [PW-1:0] pl;
        int            e;
    } beat_t;

    typedef struct {
        bit          v;
        logic [31:0] d;
        logic [3:0]  k;
        bit          l;
        bit          rdy;
        int          lvl;
        bit          sr;
        bit          mv;
        logic [31:0] td;
    } vec_t;

    beat_t q[$];
    int    vecs = 0;
    int    errs = 0;
    int    edge_n = 0;
    bit    exp_srdy = 1'b0;
    bit    mv = 1'b0;
    bit    last_push, last_pop;

    function automatic logic [PW-1:0] s_pl();
        return {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
    endfunction

    function automatic logic [PW-1:0] m_pl();
        return {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] d,
                         input logic [3:0] k, input bit l, input bit rdy);
        s_tvalid = v;
        s_tdata  = d;
        s_tkeep  = k;
        s_tstrb  = d[3:0];
        s_tlast  = l;
        s_tid    = d[7:0];
        s_tdest  = d[11:8];
        s_tuser  = d[12:12];
        m_tready = rdy;
    endtask

    task automatic rand_drive();
        s_tvalid = ($urandom_range(3) != 0);
        s_tdata  = $urandom;
        s_tstrb  = 4'($urandom);
        s_tkeep  = ($urandom_range(4) == 0) ? 4'h0 : 4'($urandom);
        s_tlast  = ($urandom_range(3) == 0);
        s_tid    = 8'($urandom);
        s_tdest  = 4'($urandom);
        s_tuser  = 1'($urandom);
        m_tready = ($urandom_range(2) != 0);
    endtask

    // One clock edge: model takes the handshakes seen before the edge,
    // then DUT outputs are compared just after it.
    task automatic step();
        bit            p, o;
        logic [PW-1:0] pl;
        beat_t         nb;
        beat_t         ob;
        int            nl;
        bit            allowed;
        p  = s_tvalid && exp_srdy && ((s_tkeep != 4'h0) || s_tlast);
        o  = mv && m_tready;
        pl = s_pl();
        @(posedge clk);
        edge_n++;
        if (o && q.size() > 0) ob = q.pop_front();
        if (p) begin
            nb.pl = pl;
            nb.e  = edge_n;
            q.push_back(nb);
        end
        last_push = p;
        last_pop  = o;
        exp_srdy  = (q.size() < DEPTH);
        #1;
        chk("level", 64'(level), 64'(q.size()));
        chk("s_tready", 64'(s_tready), 64'(exp_srdy));
`ifndef MIO_AXIS_FIFO_PKT_MODE_EN
        // head beat shows from the edge after it was stored
        mv = (q.size() > 0) && (q[0].e < edge_n);
        chk("m_tvalid", 64'(m_tvalid), 64'(mv));
        if (mv) chk("payload", 64'(m_pl()), 64'(q[0].pl));
`else
        nl = 0;
        foreach (q[i]) if (q[i].pl[LASTB]) nl++;
        allowed = (q.size() > 0) && ((nl > 0) || (q.size() == DEPTH));
        chk("pkt_gate", 64'(m_tvalid & ~allowed), 64'(0));
        mv = m_tvalid;
        if (m_tvalid && q.size() > 0)
            chk("payload", 64'(m_pl()), 64'(q[0].pl));
`endif
    endtask

    task automatic drain();
        int n;
        n = 0;
        drive(1'b0, '0, 4'h0, 1'b0, 1'b1);
        while (q.size() > 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain_level", 64'(level), 64'(0));
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        q.delete();
        exp_srdy = 1'b0;
        mv       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_srdy", 64'(s_tready), 64'(0));
        chk("rst_mvalid", 64'(m_tvalid), 64'(0));
        chk("rst_payload", 64'(m_pl()), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, '0, 4'h0, 1'b0, 1'b0);
        step();
        chk("srdy_post_rst", 64'(s_tready), 64'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   cnt;
        int   sent;
        int   outn;
        bit   first;

        tbl[0] = '{1, 32'hA5A5A5A5, 4'hF, 0, 1, 1, 1, 0, 32'h0};
        tbl[1] = '{0, 32'h0,        4'h0, 0, 1, 1, 1, 1, 32'hA5A5A5A5};
        tbl[2] = '{0, 32'h0,        4'h0, 0, 1, 0, 1, 0, 32'h0};
        tbl[3] = '{1, 32'h11111111, 4'h0, 0, 1, 0, 1, 0, 32'h0};
        tbl[4] = '{1, 32'h22222222, 4'h0, 1, 1, 1, 1, 0, 32'h0};
        tbl[5] = '{0, 32'h0,        4'h0, 0, 0, 1, 1, 1, 32'h22222222};
        tbl[6] = '{0, 32'h0,        4'h0, 0, 0, 1, 1, 1, 32'h22222222};
        tbl[7] = '{0, 32'h0,        4'h0, 0, 1, 0, 1, 0, 32'h0};

        drive(1'b0, '0, 4'h0, 1'b0, 1'b0);
        do_reset();

`ifndef MIO_AXIS_FIFO_PKT_MODE_EN
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].k, tbl[i].l, tbl[i].rdy);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_level", i), 64'(level), 64'(tbl[i].lvl));
            chk($sformatf("tbl%0d_srdy", i), 64'(s_tready), 64'(tbl[i].sr));
            chk($sformatf("tbl%0d_mvalid", i), 64'(m_tvalid), 64'(tbl[i].mv));
            if (tbl[i].mv)
                chk($sformatf("tbl%0d_tdata", i), 64'(m_tdata), 64'(tbl[i].td));
        end
        q.delete();
        exp_srdy = 1'b1;
        mv       = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h100 + i, 4'hF, 1'b0, 1'b0);
            step();
        end
        chk("full_level", 64'(level), 64'(16));
        chk("full_srdy", 64'(s_tready), 64'(0));
        drive(1'b1, 32'hDEAD, 4'hF, 1'b0, 1'b0);
        repeat (2) step();
        chk("held_level", 64'(level), 64'(16));
        cnt = 0;
        drive(1'b0, '0, 4'h0, 1'b0, 1'b1);
        for (int n = 0; n < 40 && q.size() > 0; n++) begin
            step();
            if (last_pop) cnt++;
        end
        chk("drain16_cnt", 64'(cnt), 64'(16));
        chk("drain16_level", 64'(level), 64'(0));

        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 32'h200 + i, 4'hF, 1'b0, 1'b0);
            step();
        end
        chk("l15_level", 64'(level), 64'(15));
        drive(1'b1, 32'h300, 4'hF, 1'b0, 1'b1);
        step();
        chk("l15_pp_level", 64'(level), 64'(15));
        chk("l15_pp_srdy", 64'(s_tready), 64'(1));
        drain();

        drive(1'b1, 32'h310, 4'hF, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 4'h0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h311, 4'hF, 1'b0, 1'b1);
        step();
        chk("l1_pp_level", 64'(level), 64'(1));
        drain();
`else
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h400 + i, 4'hF, i == 2, 1'b1);
            step();
            chk("pkt_wait", 64'(m_tvalid), 64'(0));
        end
        drive(1'b0, '0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pkt_b2b_v", 64'(m_tvalid), 64'(1));
            chk("pkt_b2b_d", 64'(m_tdata), 64'(32'h400 + i));
        end
        step();
        chk("pkt_end_v", 64'(m_tvalid), 64'(0));
        chk("pkt_end_level", 64'(level), 64'(0));

        sent  = 0;
        outn  = 0;
        first = 1'b1;
        for (int c = 0; c < 400 && outn < 20; c++) begin
            if (sent < 20)
                drive(1'b1, 32'h500 + sent, 4'hF, sent == 19, 1'b1);
            else
                drive(1'b0, '0, 4'h0, 1'b0, 1'b1);
            step();
            if (last_push) sent++;
            if (last_pop) outn++;
            if (m_tvalid && first) begin
                first = 1'b0;
                chk("pkt20_first_level", 64'(level), 64'(16));
            end
        end
        chk("pkt20_out", 64'(outn), 64'(20));
        drain();
`endif

        drive(1'b1, 32'h600, 4'hF, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            s_tdata = 32'h600 + i;
            step();
        end
        chk("pre_rst_level", 64'(level), 64'(5));
        drive(1'b0, '0, 4'h0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        reset_n  = 1'b0;
        q.delete();
        exp_srdy = 1'b0;
        mv       = 1'b0;
        #1;
        chk("async_rst_level", 64'(level), 64'(0));
        chk("async_rst_mvalid", 64'(m_tvalid), 64'(0));
        chk("async_rst_tdata", 64'(m_tdata), 64'(0));
        chk("async_rst_srdy", 64'(s_tready), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("rel_srdy", 64'(s_tready), 64'(1));

        for (int i = 0; i < 3000; i++) begin
            rand_drive();
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
